// File: rtl/dither_pkg.sv
// dither_pkg: frame geometry, diffusion weights, error types and
// the 0..255 clamp shared by the Floyd-Steinberg dither stage.
package dither_pkg;

  localparam int FRAME_WIDTH  = 320;
  localparam int FRAME_HEIGHT = 240;
  localparam int THRESHOLD    = 128;

  localparam int W_R         = 7;
  localparam int W_DL        = 3;
  localparam int W_D         = 5;
  localparam int W_DR        = 1;
  localparam int SHARE_SHIFT = 4;

  typedef logic signed [8:0]  err_t;
  typedef logic signed [10:0] acc_t;
  typedef logic signed [11:0] prod_t;

  function automatic logic [7:0] clamp8(acc_t v);
    if (v[10])
      return 8'd0;
    if (v > acc_t'(11'sd255))
      return 8'd255;
    return v[7:0];
  endfunction

endpackage

// File: rtl/fs_error_split.sv
// fs_error_split: splits a quantisation error into its four
// floor-rounded shares. in: e; out: r, dl, d, dr.
module fs_error_split
  import dither_pkg::*;
(
  input  err_t e,
  output err_t r,
  output err_t dl,
  output err_t d,
  output err_t dr
);

  prod_t ex;
  prod_t p_r;
  prod_t p_dl;
  prod_t p_d;
  prod_t p_dr;

  assign ex   = prod_t'(e);
  assign p_r  = ex * prod_t'(W_R);
  assign p_dl = ex * prod_t'(W_DL);
  assign p_d  = ex * prod_t'(W_D);
  assign p_dr = ex * prod_t'(W_DR);

  // arithmetic shift gives floor rounding for negative errors
  assign r  = err_t'(p_r  >>> SHARE_SHIFT);
  assign dl = err_t'(p_dl >>> SHARE_SHIFT);
  assign d  = err_t'(p_d  >>> SHARE_SHIFT);
  assign dr = err_t'(p_dr >>> SHARE_SHIFT);

endmodule

// File: rtl/fs_dither_core.sv
// fs_dither_core: 1-bit Floyd-Steinberg quantiser. in: cur/below
// pixel + position; out: dith_* pixel, upd_* next-row write-back.
module fs_dither_core
  import dither_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  cur_pixel,
  input  logic [7:0]  below_pixel,
  input  logic [10:0] in_hcount,
  input  logic [9:0]  in_vcount,
  input  logic        in_valid,
  output logic        dith_pixel,
  output logic [10:0] dith_hcount,
  output logic [9:0]  dith_vcount,
  output logic        dith_valid,
  output logic [7:0]  upd_pixel,
  output logic [10:0] upd_hcount,
  output logic        upd_valid
);

  err_t       carry;
  acc_t       acc_prev;
  acc_t       acc_cur;
  logic [7:0] below_prev;
  logic       flush_pend;

  logic       take;
  logic       first;
  logic       last;
  logic       last_row;
  err_t       c_eff;
  acc_t       ac_eff;
  acc_t       sum_raw;
  logic [7:0] sum;
  logic       q;
  acc_t       e_full;
  err_t       e;
  err_t       r;
  err_t       dl;
  err_t       d;
  err_t       dr;
  acc_t       upd_sum;
  acc_t       flush_sum;

  fs_error_split u_split (
    .e  (e),
    .r  (r),
    .dl (dl),
    .d  (d),
    .dr (dr)
  );

  always_comb begin
    take     = in_valid && (in_hcount < 11'(FRAME_WIDTH));
    first    = (in_hcount == 11'd0);
    last     = (in_hcount == 11'(FRAME_WIDTH - 1));
    last_row = (in_vcount == 10'(FRAME_HEIGHT - 1));
    // column 0 never inherits state from the previous row
    c_eff    = first ? err_t'(0) : carry;
    ac_eff   = first ? acc_t'(0) : acc_cur;
    sum_raw  = acc_t'({3'b000, cur_pixel}) + acc_t'(c_eff);
    sum      = clamp8(sum_raw);
    q        = (sum >= 8'(THRESHOLD));
    e_full   = acc_t'({3'b000, sum})
             - (q ? acc_t'(11'sd255) : acc_t'(11'sd0));
    e        = err_t'(e_full);
    upd_sum  = acc_t'({3'b000, below_prev}) + acc_prev
             + acc_t'(dl);
    flush_sum = acc_t'({3'b000, below_prev}) + acc_prev;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      carry       <= '0;
      acc_prev    <= '0;
      acc_cur     <= '0;
      below_prev  <= '0;
      flush_pend  <= 1'b0;
      dith_pixel  <= 1'b0;
      dith_hcount <= '0;
      dith_vcount <= '0;
      dith_valid  <= 1'b0;
      upd_pixel   <= '0;
      upd_hcount  <= '0;
      upd_valid   <= 1'b0;
    end else begin
      dith_valid <= 1'b0;
      upd_valid  <= 1'b0;

      // write back the last column once its row is finished
      if (flush_pend) begin
        upd_pixel  <= clamp8(flush_sum);
        upd_hcount <= 11'(FRAME_WIDTH - 1);
        upd_valid  <= 1'b1;
        acc_prev   <= '0;
        acc_cur    <= '0;
        flush_pend <= 1'b0;
      end

      // a column-0 pixel in the flush cycle overrides the clear
      if (take) begin
        dith_pixel  <= q;
        dith_hcount <= in_hcount;
        dith_vcount <= in_vcount;
        dith_valid  <= 1'b1;
        carry       <= last ? err_t'(0) : r;
        if (!first && !last_row) begin
          upd_pixel  <= clamp8(upd_sum);
          upd_hcount <= in_hcount - 11'd1;
          upd_valid  <= 1'b1;
        end
        acc_prev   <= ac_eff + acc_t'(d);
        acc_cur    <= last ? acc_t'(0) : acc_t'(dr);
        below_prev <= below_pixel;
        flush_pend <= last && !last_row;
      end
    end
  end

endmodule

// File: tb/tb_fs_dither_core.sv
// tb_fs_dither_core: random + directed stimulus against a
// row-level error-diffusion model with in-order output queues.
module tb_fs_dither_core;

  localparam int FW = 320;
  localparam int FH = 240;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  cur_pixel;
  logic [7:0]  below_pixel;
  logic [10:0] in_hcount;
  logic [9:0]  in_vcount;
  logic        in_valid;
  logic        dith_pixel;
  logic [10:0] dith_hcount;
  logic [9:0]  dith_vcount;
  logic        dith_valid;
  logic [7:0]  upd_pixel;
  logic [10:0] upd_hcount;
  logic        upd_valid;

  int n_chk = 0;
  int n_err = 0;
  int n_upd = 0;

  int dq[$];
  int uq[$];

  int m_carry;
  int m_err[0:FW];
  int m_below[0:FW-1];

  always #5 clk_in = ~clk_in;

  fs_dither_core dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .cur_pixel   (cur_pixel),
    .below_pixel (below_pixel),
    .in_hcount   (in_hcount),
    .in_vcount   (in_vcount),
    .in_valid    (in_valid),
    .dith_pixel  (dith_pixel),
    .dith_hcount (dith_hcount),
    .dith_vcount (dith_vcount),
    .dith_valid  (dith_valid),
    .upd_pixel   (upd_pixel),
    .upd_hcount  (upd_hcount),
    .upd_valid   (upd_valid)
  );

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int fl16(int n);
    return (n >= 0) ? n / 16 : -((-n + 15) / 16);
  endfunction

  function automatic int clip(int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  function automatic int upd_word(int x);
    return clip(m_below[x] + m_err[x]) | (x << 8);
  endfunction

  // one accepted pixel: quantise, spread error, queue outputs
  task automatic model_accept(int cur, int below, int x, int v);
    int s, q, e;
    if (x == 0) begin
      m_carry = 0;
      for (int i = 0; i <= FW; i++) m_err[i] = 0;
    end
    s = clip(cur + m_carry);
    q = (s >= 128) ? 1 : 0;
    e = s - (q ? 255 : 0);
    dq.push_back(q | (x << 1) | (v << 12));
    m_carry = (x == FW - 1) ? 0 : fl16(7 * e);
    if (x > 0) m_err[x-1] += fl16(3 * e);
    m_err[x] += fl16(5 * e);
    if (x < FW - 1) m_err[x+1] += fl16(e);
    m_below[x] = below;
    if (v != FH - 1) begin
      if (x > 0) uq.push_back(upd_word(x - 1));
      if (x == FW - 1) uq.push_back(upd_word(x));
    end
  endtask

  task automatic beat(bit vld, int cur, int below, int h, int v);
    in_valid    = vld;
    cur_pixel   = 8'(cur);
    below_pixel = 8'(below);
    in_hcount   = 11'(h);
    in_vcount   = 10'(v);
    if (vld && h < FW) model_accept(cur, below, h, v);
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    beat(0, $urandom_range(255), $urandom_range(255), 0, 0);
  endtask

  task automatic settle();
    @(negedge clk_in);
    #1;
  endtask

  task automatic do_reset(string tag);
    rst_in   = 1'b1;
    in_valid = 1'b0;
    @(posedge clk_in);
    #1;
    dq.delete();
    uq.delete();
    chk({tag, "_dv"}, int'(dith_valid), 0);
    chk({tag, "_dp"}, int'(dith_pixel), 0);
    chk({tag, "_dh"}, int'(dith_hcount), 0);
    chk({tag, "_dvc"}, int'(dith_vcount), 0);
    chk({tag, "_uv"}, int'(upd_valid), 0);
    chk({tag, "_up"}, int'(upd_pixel), 0);
    chk({tag, "_uh"}, int'(upd_hcount), 0);
    rst_in = 1'b0;
  endtask

  // mode 0 random, 1 black/below 200, 2 constant 128
  task automatic drive_row(int v, int mode, bit gaps);
    int c, b;
    for (int x = 0; x < FW; x++) begin
      if (gaps && $urandom_range(7) == 0) idle();
      if (gaps && $urandom_range(15) == 0)
        beat(1, $urandom_range(255), $urandom_range(255),
             FW + $urandom_range(500), v);
      c = (mode == 1) ? 0 : (mode == 2) ? 128 : $urandom_range(255);
      b = (mode == 1) ? 200 : (mode == 2) ? 128 : $urandom_range(255);
      beat(1, c, b, x, v);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (dith_valid) begin
        chk("dith_q_nonempty", int'(dq.size() > 0), 1);
        if (dq.size() > 0)
          chk("dith", int'({dith_vcount, dith_hcount, dith_pixel}),
              dq.pop_front());
      end
      if (upd_valid) begin
        n_upd++;
        chk("upd_q_nonempty", int'(uq.size() > 0), 1);
        if (uq.size() > 0)
          chk("upd", int'({upd_hcount, upd_pixel}), uq.pop_front());
      end
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst_in      = 1'b1;
    in_valid    = 1'b0;
    cur_pixel   = '0;
    below_pixel = '0;
    in_hcount   = '0;
    in_vcount   = '0;
    repeat (2) @(posedge clk_in);
    #1;
    do_reset("rst");

    // short row: carry 43 then e=-112, write-back 60
    beat(1, 100, 50, 0, 0);
    chk("t1_dith0", int'(dith_pixel), 0);
    chk("t1_updv0", int'(upd_valid), 0);
    beat(1, 100, 50, 1, 0);
    chk("t1_dith1", int'(dith_pixel), 1);
    chk("t1_updv1", int'(upd_valid), 1);
    chk("t1_updh", int'(upd_hcount), 0);
    chk("t1_updp", int'(upd_pixel), 60);

    // saturating sum, then a negative write-back clamped to 0
    beat(1, 127, 0, 0, 1);
    beat(1, 250, 0, 1, 1);
    chk("clamp_dith", int'(dith_pixel), 1);
    chk("clamp_upd39", int'(upd_pixel), 39);
    beat(1, 128, 0, 2, 1);
    chk("neg_dith", int'(dith_pixel), 1);
    chk("neg_updh", int'(upd_hcount), 1);
    chk("neg_upd0", int'(upd_pixel), 0);
    for (int x = 3; x <= 150; x++)
      beat(1, $urandom_range(255), $urandom_range(255), x, 1);
    do_reset("midrow");
    base = n_upd;
    repeat (3) idle();
    settle();
    chk("midrow_noflush", n_upd - base, 0);

    // fresh row after reset
    beat(1, 100, 50, 0, 2);
    chk("fresh_dith", int'(dith_pixel), 0);
    chk("fresh_updv", int'(upd_valid), 0);
    for (int x = 1; x < FW; x++)
      beat(1, $urandom_range(255), $urandom_range(255), x, 2);
    idle();
    idle();

    // black row: every column written back as 200
    base = n_upd;
    drive_row(5, 1, 0);
    idle();
    chk("flush_v", int'(upd_valid), 1);
    chk("flush_h", int'(upd_hcount), FW - 1);
    chk("flush_p", int'(upd_pixel), 200);
    settle();
    chk("black_cnt", n_upd - base, FW);

    // mid-grey into the last row, back to back
    base = n_upd;
    drive_row(FH - 2, 2, 0);
    drive_row(FH - 1, 2, 0);
    idle();
    chk("lastrow_noflush", int'(upd_valid), 0);
    settle();
    chk("lastrow_cnt", n_upd - base, FW);

    // random rows, column 0 taken in the flush cycle
    drive_row(10, 0, 1);
    beat(1, 100, 50, 0, 11);
    chk("b2b_flushv", int'(upd_valid), 1);
    chk("b2b_flushh", int'(upd_hcount), FW - 1);
    chk("b2b_col0", int'(dith_pixel), 0);
    for (int x = 1; x < FW; x++)
      beat(1, $urandom_range(255), $urandom_range(255), x, 11);
    drive_row(12, 0, 1);
    drive_row(FH - 1, 0, 1);
    drive_row(13, 0, 0);

    // reset in the flush cycle drops the flush beat
    base = n_upd;
    do_reset("flushrst");
    repeat (2) idle();
    settle();
    chk("flushrst_cnt", n_upd - base, 0);

    repeat (4) idle();
    settle();
    chk("dq_drained", dq.size(), 0);
    chk("uq_drained", uq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
